// File: rtl/pad_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : pad_uart_rx
// Description : UART receiver fed directly from an input pad. The pad input
//               is synchronised with two preset flops. A falling edge on the
//               synchronised line starts a frame, and each bit is sampled at
//               its centre. A good frame raises a one-cycle valid strobe; a
//               low stop bit raises a one-cycle frame_err strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] C_HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] C_BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic                 sync1_q;
  logic                 d_s_q;
  logic                 d_s_prev_q;
  state_t               state_q;
  logic [CW-1:0]        clk_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 busy_q;

  // Two-flop synchroniser plus edge-detect history, all preset to idle-high
  // so a line that is already high at reset release never looks like a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      d_s_q      <= 1'b1;
      d_s_prev_q <= 1'b1;
    end else begin
      sync1_q    <= d;
      d_s_q      <= sync1_q;
      d_s_prev_q <= d_s_q;
    end
  end

  // Frame FSM: half-bit wait to the start-bit centre, then full-bit spacing
  // to each data bit and the stop bit. The strobes are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Edge-triggered: a line held low never starts a second frame.
          if (d_s_prev_q && !d_s_q) begin
            state_q   <= START;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt_q == C_HALF_END) begin
            clk_cnt_q <= '0;
            if (d_s_q) begin
              // Glitch shorter than half a bit: false start.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + C_CNT_ONE;
          end
        end
        DATA: begin
          if (clk_cnt_q == C_BIT_END) begin
            clk_cnt_q <= '0;
            shift_q   <= {d_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == C_LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + C_BIT_ONE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + C_CNT_ONE;
          end
        end
        STOP: begin
          if (clk_cnt_q == C_BIT_END) begin
            // Back to IDLE at the sample edge so that a start bit right
            // after the stop bit is caught.
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            if (d_s_q) begin
              data_out_q <= shift_q;
              valid_q    <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + C_CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_uart_rx
// Description : Self-checking bench for pad_uart_rx. Two instances are used
//               (16 clk/bit x 8 bits and 4 clk/bit x 5 bits). Frames are
//               driven bit-serially, and the outcome is compared against
//               frame-level expectations computed from the bit timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       d16;
  logic       d4;
  logic [7:0] dout16;
  logic [4:0] dout4;
  logic       valid16, valid4;
  logic       ferr16, ferr4;
  logic       busy16, busy4;

  int checks   = 0;
  int failures = 0;

  // Per-frame observations
  int         nvalid, nerr, vedge, eedge;
  logic [7:0] vdata;
  int         both_hi;
  logic       busy_late;
  logic       busy_trace [0:511];

  // Last good word per instance (reset clears it)
  logic [7:0] good16, good4;

  pad_uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) u_dut16 (
    .clk(clk), .rst(rst), .d(d16),
    .data_out(dout16), .valid(valid16), .frame_err(ferr16), .busy(busy16)
  );

  pad_uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(5)) u_dut4 (
    .clk(clk), .rst(rst), .d(d4),
    .data_out(dout4), .valid(valid4), .frame_err(ferr4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb(input bit sel);
    return sel ? 4 : 16;
  endfunction

  function automatic int nbits(input bit sel);
    return sel ? 5 : 8;
  endfunction

  // The pin level is captured by the first edge, becomes d_s on the second,
  // and the falling edge is acted on at the third edge (t0 = sample 3). The
  // stop bit centre is half a bit plus (bits+1) whole bits later. The strobe
  // register is set on that edge, so it is visible in the sample taken just
  // after it.
  function automatic int strobe_at(input bit sel);
    return 3 + cpb(sel) / 2 + (nbits(sel) + 1) * cpb(sel);
  endfunction

  task automatic sample(input bit sel, input int i);
    logic       v, e, b;
    logic [7:0] dat;
    v   = sel ? valid4 : valid16;
    e   = sel ? ferr4  : ferr16;
    b   = sel ? busy4  : busy16;
    dat = sel ? {3'b000, dout4} : dout16;
    if (i < 512) busy_trace[i] = b;
    if (v && e) both_hi++;
    if (v) begin nvalid++; vedge = i; vdata = dat; end
    if (e) begin nerr++; eedge = i; end
    if (!v && !e && (vedge > 0 || eedge > 0) && b) busy_late = 1'b1;
  endtask

  task automatic clear_obs();
    nvalid = 0; nerr = 0; vedge = 0; eedge = 0; vdata = '0;
    both_hi = 0; busy_late = 1'b0;
    for (int k = 0; k < 512; k++) busy_trace[k] = 1'b0;
  endtask

  task automatic drive(input bit sel, input logic val);
    if (sel) d4 = val; else d16 = val;
  endtask

  // Drive one frame (start, LSB-first data, stop) followed by tail cycles at
  // tail_val. When rst_at > 0 a one-cycle reset is applied at that cycle,
  // and the sender goes idle from then on.
  task automatic run_frame(input bit sel, input logic [7:0] word, input logic stopb,
                           input int tail, input logic tail_val, input int rst_at);
    int   c, n, total, b;
    logic val;
    c = cpb(sel);
    n = nbits(sel);
    total = (n + 2) * c + tail;
    clear_obs();
    for (int i = 1; i <= total; i++) begin
      b = (i - 1) / c;
      if (b == 0)       val = 1'b0;
      else if (b <= n)  val = word[b-1];
      else if (b == n+1) val = stopb;
      else              val = tail_val;
      if (rst_at > 0 && i >= rst_at) val = 1'b1;
      drive(sel, val);
      rst = (i == rst_at);
      @(posedge clk);
      #1;
      sample(sel, i);
    end
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input bit sel, input int cnt);
    drive(sel, 1'b1);
    repeat (cnt) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] w;
    logic       sb;
    bit         sel;
    int         tl;

    rst = 1'b1; d16 = 1'b1; d4 = 1'b1;
    good16 = '0; good4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout16", dout16, 8'h00);
    chk("rst_valid16", valid16, 1'b0);
    chk("rst_ferr16", ferr16, 1'b0);
    chk("rst_busy16", busy16, 1'b0);
    chk("rst_dout4", dout4, 5'h00);
    chk("rst_busy4", busy4, 1'b0);
    rst = 1'b0;
    idle_cycles(0, 4);
    chk("no_false_start16", busy16, 1'b0);
    chk("no_false_start4", busy4, 1'b0);

    // Good frame 0xA5
    run_frame(0, 8'hA5, 1'b1, 16, 1'b1, 0);
    good16 = 8'hA5;
    chk("a5_nvalid", nvalid, 1);
    chk("a5_vedge", vedge, strobe_at(0));
    chk("a5_data", vdata, 8'hA5);
    chk("a5_nerr", nerr, 0);
    chk("a5_busy_pre_t0", busy_trace[2], 1'b0);
    chk("a5_busy_t0", busy_trace[3], 1'b1);
    chk("a5_busy_stop", busy_trace[strobe_at(0) - 1], 1'b1);
    chk("a5_busy_after", busy_late, 1'b0);

    // Four-cycle glitch: START entered, back to IDLE half a bit after t0
    clear_obs();
    for (int i = 1; i <= 40; i++) begin
      d16 = (i <= 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      sample(0, i);
    end
    chk("glitch_busy_t0", busy_trace[3], 1'b1);
    chk("glitch_busy_last", busy_trace[3 + 8 - 1], 1'b1);
    chk("glitch_busy_end", busy_trace[3 + 8], 1'b0);
    chk("glitch_nvalid", nvalid, 0);
    chk("glitch_nerr", nerr, 0);

    // Stop bit low; the line stays low afterwards and must not restart
    run_frame(0, 8'h3C, 1'b0, 40, 1'b0, 0);
    chk("ferr_nerr", nerr, 1);
    chk("ferr_eedge", eedge, strobe_at(0));
    chk("ferr_nvalid", nvalid, 0);
    chk("ferr_hold_busy", busy_late, 1'b0);
    chk("ferr_dout_kept", dout16, good16);
    idle_cycles(0, 8);
    chk("ferr_idle_busy", busy16, 1'b0);

    // Back-to-back frames, second start immediately after the first stop
    run_frame(0, 8'h00, 1'b1, 0, 1'b1, 0);
    chk("b2b0_nvalid", nvalid, 1);
    chk("b2b0_data", vdata, 8'h00);
    run_frame(0, 8'hFF, 1'b1, 16, 1'b1, 0);
    good16 = 8'hFF;
    chk("b2b1_nvalid", nvalid, 1);
    chk("b2b1_vedge", vedge, strobe_at(0));
    chk("b2b1_data", vdata, 8'hFF);

    // Reset during data bit 3 of 0x55
    run_frame(0, 8'h55, 1'b1, 16, 1'b1, 4 * 16 + 5);
    good16 = 8'h00;
    chk("rst_mid_busy_before", busy_trace[4 * 16 + 4], 1'b1);
    chk("rst_mid_busy_after", busy_trace[4 * 16 + 5], 1'b0);
    chk("rst_mid_nvalid", nvalid, 0);
    chk("rst_mid_nerr", nerr, 0);
    chk("rst_mid_dout", dout16, good16);
    run_frame(0, 8'h81, 1'b1, 16, 1'b1, 0);
    good16 = 8'h81;
    chk("post_rst_nvalid", nvalid, 1);
    chk("post_rst_data", vdata, 8'h81);

    // Narrow instance: 4 clk/bit, 5 data bits
    run_frame(1, 8'h13, 1'b1, 8, 1'b1, 0);
    good4 = 8'h13;
    chk("c4_nvalid", nvalid, 1);
    chk("c4_vedge", vedge, strobe_at(1));
    chk("c4_data", vdata, 8'h13);

    // Randomised frames on both instances
    for (int k = 0; k < 12; k++) begin
      sel = 1'($urandom_range(0, 1));
      w   = 8'($urandom) & 8'((1 << nbits(sel)) - 1);
      sb  = ($urandom_range(0, 3) != 0);
      tl  = $urandom_range(2, 20);
      run_frame(sel, w, sb, tl, 1'b1, 0);
      if (sb) begin
        if (sel) good4 = w; else good16 = w;
      end
      chk("rnd_nvalid", nvalid, sb ? 1 : 0);
      chk("rnd_nerr", nerr, sb ? 0 : 1);
      chk("rnd_edge", sb ? vedge : eedge, strobe_at(sel));
      chk("rnd_dout", sel ? {3'b000, dout4} : dout16, sel ? good4 : good16);
      chk("rnd_both", both_hi, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pad_uart_rx.md
PAD_UART_RX -- requirements
Module: pad_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 4..65535, even values only.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port d  input  1  serial pad input (PADDI side of input IO primitive); asynchronous to clk; idle-high.
REQ-006 Port data_out  output  DATA_BITS  last correctly framed received word.
REQ-007 Port valid  output  1  one-cycle strobe: data_out updated with a good frame.
REQ-008 Port frame_err  output  1  one-cycle strobe: stop bit sampled low.
REQ-009 Port busy  output  1  high whenever FSM not in IDLE.

Function
REQ-010 d SHALL pass through a 2-flop synchronizer; d_s = second-flop output; all logic SHALL use d_s only.
REQ-011 FSM states SHALL be exactly IDLE, START, DATA, STOP.
REQ-012 IDLE: on d_s falling edge (previous d_s 1, current 0), define cycle t0; FSM SHALL enter START, bit counter cleared, clock counter cleared.
REQ-013 START: at t0 + CLKS_PER_BIT/2, d_s sampled; 0 -> DATA, clock counter restarted; 1 -> false start, return to IDLE, no strobe.
REQ-014 DATA: bit k (k = 0..DATA_BITS-1, LSB first) SHALL be sampled at t0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT into a shift register.
REQ-015 After bit DATA_BITS-1 sampled, FSM SHALL enter STOP; stop sampled at t0 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT.
REQ-016 Stop sample 1: data_out loaded from shift register and valid high in the next cycle for exactly one cycle.
REQ-017 Stop sample 0: frame_err high in the next cycle for exactly one cycle; data_out unchanged; valid stays low.
REQ-018 After stop sample FSM SHALL return to IDLE in the same edge; a falling edge of d_s in the strobe cycle SHALL be accepted as a new t0 (back-to-back frames, no lost frame).
REQ-019 After a frame_err with d_s held low, no new start SHALL be detected until d_s has returned to 1 (edge-triggered start only).
REQ-020 valid and frame_err SHALL never be high in the same cycle.
REQ-021 Clock counter width SHALL be ceil(log2(CLKS_PER_BIT)); counter wraps 0..CLKS_PER_BIT-1 with no off-by-one drift across a frame.
REQ-022 busy SHALL be high from the cycle after t0 through the stop-sample edge, low otherwise.

Reset
REQ-023 rst high at a clock edge SHALL force: FSM IDLE, counters 0, shift register 0, data_out 0, valid 0, frame_err 0, busy 0, both synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no strobe; first frame after deassertion requires a fresh falling edge.
REQ-025 Synchronizer preset to 1 SHALL guarantee no false start when d is already high at reset release.

Verification
REQ-026 CLKS_PER_BIT=16, DATA_BITS=8, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop 1) -> valid one cycle, data_out=0xA5, frame_err 0, valid at t0+153.
REQ-027 d low for 4 cycles then high, idle -> START entered, returns to IDLE at t0+8, no valid, no frame_err.
REQ-028 Send 0x3C with stop bit 0 -> frame_err one cycle at t0+153, data_out keeps previous value, valid 0.
REQ-029 Back-to-back 0x00 then 0xFF, second start bit beginning immediately after first stop bit -> two valid strobes, data_out 0x00 then 0xFF.
REQ-030 rst pulsed one cycle during bit 3 of 0x55 -> no strobe, busy 0 the cycle after reset; next frame 0x81 -> valid, data_out=0x81.
REQ-031 CLKS_PER_BIT=4, DATA_BITS=5, send 0x13 -> valid at t0+27, data_out=0x13.
